// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the program-download / instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned LEN_W     = 9;
  localparam int unsigned MEM_DEPTH = 256;

  localparam logic [DATA_W-1:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Download handshake plus fetch port between loader/processor and fetch_stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] data_in;
  logic              fetch_valid;
  logic [LEN_W-1:0]  prog_len;

  modport master (
    output load_start, load_valid, load_data, load_last, pc,
    input  load_ready, instruction, data_in, fetch_valid, prog_len
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, pc,
    output load_ready, instruction, data_in, fetch_valid, prog_len
  );
endinterface

// File: rtl/fetch_stage_prog_mem.sv
// 256x8 program store with per-byte loaded flags; unloaded bytes read as NOP.
module prog_mem
  import fetch_stage_pkg::*;
(
  input  logic              clk1,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a_c,
  output logic [DATA_W-1:0] rdata_b_c
);

  logic [DATA_W-1:0]    mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] flag;

  // Array is never reset; the flag vector masks stale contents.
  always_ff @(posedge clk1) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset)   flag <= '0;
    else if (clr) flag <= '0;
    else if (we)  flag[waddr] <= 1'b1;
  end

  assign rdata_a_c = flag[raddr_a] ? mem[raddr_a] : NOP;
  assign rdata_b_c = flag[raddr_b] ? mem[raddr_b] : NOP;

endmodule

// File: rtl/fetch_stage.sv
// Downloads a program byte stream into prog_mem, then serves opcode/operand pairs by pc.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic         clk1,
  input  logic         reset,
  fetch_stage_if.slave bus
);

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic              ready_q;
  logic [DATA_W-1:0] instr_q, data_q;
  logic              fv_q;
  logic              accept_c, run_c;
  logic [DATA_W-1:0] rd_a_c, rd_b_c;

  // load_start outranks a coincident byte, which is dropped.
  assign accept_c = (state_q == LOAD) && ready_q && bus.load_valid && !bus.load_start;
  assign run_c    = (state_q == RUN) && (state_nxt == RUN);

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    len_nxt   = len_q;
    if (bus.load_start) begin
      state_nxt = LOAD;
      len_nxt   = '0;
    end else if (accept_c) begin
      len_nxt = len_q + LEN_W'(1);
      if (bus.load_last || (len_q == LEN_W'(MEM_DEPTH - 1))) state_nxt = RUN;
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      instr_q <= NOP;
      data_q  <= NOP;
      fv_q    <= 1'b0;
    end else begin
      if (bus.load_start) addr_q <= '0;
      else if (accept_c)  addr_q <= addr_q + ADDR_W'(1);
      len_q   <= len_nxt;
      ready_q <= (state_nxt == LOAD) && (len_nxt < LEN_W'(MEM_DEPTH));
      instr_q <= run_c ? rd_a_c : NOP;
      data_q  <= run_c ? rd_b_c : NOP;
      fv_q    <= run_c;
    end
  end

  prog_mem u_prog_mem (
    .clk1      (clk1),
    .reset     (reset),
    .clr       (bus.load_start),
    .we        (accept_c),
    .waddr     (addr_q),
    .wdata     (bus.load_data),
    .raddr_a   (bus.pc),
    .raddr_b   (bus.pc + ADDR_W'(1)),
    .rdata_a_c (rd_a_c),
    .rdata_b_c (rd_b_c)
  );

  assign bus.load_ready  = ready_q;
  assign bus.instruction = instr_q;
  assign bus.data_in     = data_q;
  assign bus.fetch_valid = fv_q;
  assign bus.prog_len    = len_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed checks of download, fetch, masking, restart and reset behaviour.
module tb_fetch_stage;

  logic clk1 = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errs    = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic start();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    bus.pc         = 8'h00;
    #2;
    check("rst_instr", 16'(bus.instruction), 16'h00);
    check("rst_data",  16'(bus.data_in),     16'h00);
    check("rst_len",   16'(bus.prog_len),    16'h000);
    check("rst_ready", 16'(bus.load_ready),  16'h0);
    check("rst_fv",    16'(bus.fetch_valid), 16'h0);
    step(); step();
    reset = 1'b1;
    step();

    // Basic three-byte program
    start();
    check("load_ready", 16'(bus.load_ready),  16'h1);
    check("load_len0",  16'(bus.prog_len),    16'h000);
    check("load_fv",    16'(bus.fetch_valid), 16'h0);
    bus.load_valid = 1'b1;
    bus.load_data = 8'h15; step();
    bus.load_data = 8'hAA; step();
    bus.load_data = 8'h20; bus.load_last = 1'b1; step();
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    check("len3",       16'(bus.prog_len),   16'h003);
    check("run_ready0", 16'(bus.load_ready), 16'h0);
    bus.pc = 8'h00; step();
    check("pc0_instr", 16'(bus.instruction), 16'h15);
    check("pc0_data",  16'(bus.data_in),     16'hAA);
    check("pc0_fv",    16'(bus.fetch_valid), 16'h1);
    bus.pc = 8'h02; step();
    check("pc2_instr", 16'(bus.instruction), 16'h20);
    check("pc2_data",  16'(bus.data_in),     16'h00);
    bus.pc = 8'hFF; step();
    check("pcff_instr", 16'(bus.instruction), 16'h00);
    check("pcff_data",  16'(bus.data_in),     16'h15);
    send(8'h99, 1'b1);
    check("run_ignore_len", 16'(bus.prog_len), 16'h003);

    // Reload from RUN; old bytes must be masked
    start();
    check("reload_fv",    16'(bus.fetch_valid), 16'h0);
    check("reload_instr", 16'(bus.instruction), 16'h00);
    check("reload_len",   16'(bus.prog_len),    16'h000);
    check("reload_ready", 16'(bus.load_ready),  16'h1);
    send(8'h31, 1'b1);
    check("reload_len1", 16'(bus.prog_len), 16'h001);
    bus.pc = 8'h01; step();
    check("mask_instr", 16'(bus.instruction), 16'h00);
    check("mask_data",  16'(bus.data_in),     16'h00);
    bus.pc = 8'h00; step();
    check("new_instr", 16'(bus.instruction), 16'h31);

    // Full 256-byte stream without load_last
    start();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("ready_at_255", 16'(bus.load_ready), 16'h1);
      bus.load_data = 8'(i);
      step();
    end
    check("full_len",   16'(bus.prog_len),   16'h100);
    check("full_ready", 16'(bus.load_ready), 16'h0);
    bus.load_data = 8'hEE;
    step();
    bus.load_valid = 1'b0;
    check("full_len_hold", 16'(bus.prog_len), 16'h100);
    bus.pc = 8'hFE; step();
    check("fe_instr", 16'(bus.instruction), 16'hFE);
    check("fe_data",  16'(bus.data_in),     16'hFF);
    bus.pc = 8'hFF; step();
    check("ff_instr", 16'(bus.instruction), 16'hFF);
    check("ff_data",  16'(bus.data_in),     16'h00);
    check("full_fv",  16'(bus.fetch_valid), 16'h1);

    // load_start coincident with a byte drops the byte
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h77;
    start();
    bus.load_valid = 1'b0;
    check("drop_len",   16'(bus.prog_len),   16'h000);
    check("drop_ready", 16'(bus.load_ready), 16'h1);
    send(8'h42, 1'b1);
    bus.pc = 8'h00; step();
    check("drop_instr", 16'(bus.instruction), 16'h42);
    check("drop_data",  16'(bus.data_in),     16'h00);

    // Asynchronous reset in the middle of a download
    start();
    bus.load_valid = 1'b1;
    bus.load_data = 8'h01; step();
    bus.load_data = 8'h02; step();
    bus.load_valid = 1'b0;
    check("mid_len2", 16'(bus.prog_len), 16'h002);
    #2 reset = 1'b0;
    #1;
    check("async_len",   16'(bus.prog_len),    16'h000);
    check("async_ready", 16'(bus.load_ready),  16'h0);
    check("async_instr", 16'(bus.instruction), 16'h00);
    check("async_fv",    16'(bus.fetch_valid), 16'h0);
    step();
    reset = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h55;
    bus.load_last  = 1'b1;
    step(); step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    check("idle_len",   16'(bus.prog_len),    16'h000);
    check("idle_ready", 16'(bus.load_ready),  16'h0);
    check("idle_fv",    16'(bus.fetch_valid), 16'h0);
    start();
    check("post_rst_ready", 16'(bus.load_ready), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
clk1  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low; 0 clears all state immediately.
load_start  input  1  one-cycle request to begin a new program download.
load_valid  input  1  load_data carries a program byte.
load_data  input  8  program byte.
load_last  input  1  qualifies the final byte of the download; sampled with load_valid.
load_ready  output  1  block accepts a byte this cycle.
pc  input  8  fetch address driven by the downstream accumulator processor.
instruction  output  8  opcode byte for the processor (opcode in bits [7:4]).
data_in  output  8  operand byte for the processor.
fetch_valid  output  1  instruction and data_in hold real program bytes.
prog_len  output  9  number of bytes loaded, 0 to 256.

Function
REQ-002 The block SHALL hold a 256 x 8 program memory and a 256-bit loaded-flag vector.
REQ-003 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-004 IDLE SHALL move to LOAD on load_start.
REQ-005 LOAD SHALL move to RUN on an accepted byte with load_last=1.
REQ-006 LOAD SHALL move to RUN when the 256th byte is accepted, whatever load_last is.
REQ-007 RUN SHALL move to LOAD on load_start.
REQ-008 load_start in LOAD SHALL restart the download.
REQ-009 Entering LOAD SHALL clear the write address, prog_len and the loaded-flag vector in the same cycle.
REQ-010 load_ready SHALL be 1 only in LOAD and only while prog_len < 256.
REQ-011 A byte SHALL be accepted when load_valid and load_ready are both 1.
REQ-012 On acceptance, the block SHALL write the byte to mem[addr], set flag[addr], increment addr and increment prog_len.
REQ-013 load_valid in IDLE or RUN SHALL be ignored.
REQ-014 load_start takes priority: if load_start and a valid byte coincide, the byte SHALL be dropped and the download SHALL restart.
REQ-015 In RUN, instruction SHALL be registered from mem[pc] one cycle after pc is sampled.
REQ-016 In RUN, data_in SHALL be registered from mem[(pc+1) mod 256] one cycle after pc is sampled; pc=0xFF wraps to address 0x00.
REQ-017 Any read of a location whose loaded flag is 0 SHALL return 0x00 (NOP).
REQ-018 fetch_valid SHALL be 1 in every cycle after the first RUN clock edge and 0 otherwise.
REQ-019 Outside RUN, instruction and data_in SHALL be 0x00 and fetch_valid SHALL be 0.
REQ-020 On the cycle after RUN moves to LOAD, outputs SHALL drop to 0x00 and fetch_valid to 0.

Reset
REQ-021 While reset=0, the state SHALL be IDLE.
REQ-022 While reset=0, instruction, data_in, prog_len, load_ready, fetch_valid, the write address and all loaded flags SHALL be 0.
REQ-023 Memory array contents need not be reset; the cleared flags SHALL mask them.
REQ-024 A reset during LOAD or RUN SHALL abandon the download; the next cycle after release SHALL be IDLE.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the NOP opcode 0x00, and the memory depth constant 256.
REQ-026 The memory plus flag vector SHALL be one sub-module, prog_mem: one write port and two combinational read ports with flag masking.
REQ-027 The FSM, counters and output registers SHALL live in fetch_stage.

Verification
REQ-028 Reset then load_start, then bytes 0x15,0xAA,0x20 with last on 0x20 -> prog_len=3, RUN reached; pc=0 gives instruction=0x15, data_in=0xAA the following cycle.
REQ-029 After REQ-028, pc=0x02 -> instruction=0x20, data_in=0x00 (unloaded); pc=0xFF -> instruction=0x00, data_in=0x15 (wrap).
REQ-030 Stream 256 bytes of value i with load_last never set -> RUN entered after byte 255 and load_ready=0 from then; prog_len=256.
REQ-031 In RUN issue load_start, send 0x31 with last -> fetch_valid=0 during LOAD; afterwards pc=0x01 reads 0x00 (old byte masked).
REQ-032 load_start coincident with load_valid carrying 0x77 -> byte dropped, prog_len=0.
REQ-033 Drop reset mid-LOAD after 2 bytes -> all outputs 0 asynchronously; state IDLE after release; load_valid ignored until load_start.
